// File: rtl/run_sequencer.sv
// Program-run sequencer for the single-cycle core: holds the core in
// reset, releases it, then watches for completion or a runaway program.
module run_sequencer #(
  parameter int D       = 12,
  parameter int DONE_PC = 128,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  input  logic          core_we,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_din,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_din,
  output logic          host_gnt,
  output logic          mem_we,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_din
);

  localparam int RW = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

  state_t        state_q;
  logic          req_q;
  logic [RW-1:0] rcnt_q;
  logic [CW-1:0] cyc_q;
  logic          start;
  logic          core_own;

  assign start = req & ~req_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      rcnt_q  <= '0;
      cyc_q   <= '0;
    end else begin
      req_q <= req;
      unique case (state_q)
        S_IDLE, S_DONE, S_TOUT: begin
          if (start) begin
            state_q <= S_INIT;
            rcnt_q  <= '0;
            cyc_q   <= '0;
          end
        end
        S_INIT: begin
          rcnt_q <= rcnt_q + 1'b1;
          if (rcnt_q == RW'(RST_CYC - 1))
            state_q <= S_RUN;
        end
        S_RUN: begin
          // the exiting edge still counts as a run cycle
          cyc_q <= cyc_q + 1'b1;
          if (prog_ctr == D'(DONE_PC))
            state_q <= S_DONE;
          else if (cyc_q == CW'(TIMEOUT - 1))
            state_q <= S_TOUT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_own = (state_q == S_INIT) | (state_q == S_RUN);
  assign core_rst = (state_q == S_IDLE) | (state_q == S_INIT);
  assign core_en  = (state_q == S_RUN);
  assign busy     = core_own;
  assign done     = (state_q == S_DONE);
  assign timeout  = (state_q == S_TOUT);
  assign cycles   = cyc_q;

  // host is shut out while the core may touch memory; no queuing
  assign host_gnt = ~core_own & host_req;
  assign mem_we   = core_own ? (core_we & core_en)
                             : (host_req & host_we);
  assign mem_addr = core_own ? core_addr : host_addr;
  assign mem_din  = core_own ? core_din : host_din;

endmodule
